instr_fetch_unit: RTL and testbench

- Fetch stage directly upstream of the instruction decoder/controller in the RISC-V single-cycle CPU.
- Owns the PC register and drives a req/ack instruction-memory port with variable latency.
- Presents one instruction at a time to decode through a valid/ready handshake.
- Computes the next PC from the Branch/Jal/Jalr decisions returned by decode and execute when the instruction is accepted.

---
 rtl/instr_fetch_unit.sv | 134 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches over a req/ack memory port and hands one
// instruction at a time to decode. Optional misaligned-target trap: MISALIGN_CHK_EN.
module instr_fetch_unit #(
  parameter int unsigned          ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = 32'h0000_0000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [31:0]       imem_rdata_i,
  output logic [31:0]       instr_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  input  logic              branch_i,
  input  logic              zero_i,
  input  logic              jal_i,
  input  logic              jalr_i,
  input  logic [ADDR_W-1:0] imm_i,
  input  logic [ADDR_W-1:0] rs1_data_i,
  output logic              fault_o
);

  localparam int unsigned     ST_W   = 2;
  localparam logic [31:0]     NOP    = 32'h0000_0013;
  localparam logic [ST_W-1:0] S_IDLE = 2'd0;
  localparam logic [ST_W-1:0] S_REQ  = 2'd1;
  localparam logic [ST_W-1:0] S_HOLD = 2'd2;
`ifdef MISALIGN_CHK_EN
  localparam logic [ST_W-1:0] S_FAULT = 2'd3;
`endif

  logic [ST_W-1:0]   r_state;
  logic [ST_W-1:0]   w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_instr;
  logic              r_req;
  logic              r_valid;
  logic              w_accept;
  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W-1:0] w_pc_load;
`ifdef MISALIGN_CHK_EN
  logic              r_fault;
  logic              w_misalign;
`endif

  // Branch/jump target resolution; jalr outranks jal outranks a taken branch.
  always_comb begin
    w_target = r_pc + ADDR_W'(4);
    if (jalr_i) begin
      w_target = (rs1_data_i + imm_i) & ~ADDR_W'(1);
    end else if (jal_i || (branch_i && zero_i)) begin
      w_target = r_pc + imm_i;
    end
  end

`ifdef MISALIGN_CHK_EN
  // The misaligned target is still loaded so the faulting PC stays visible.
  assign w_misalign = |w_target[1:0];
  assign w_pc_load  = w_target;
`else
  assign w_pc_load  = w_target & ~ADDR_W'(3);
`endif

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: w_state_nxt = S_REQ;
      S_REQ: begin
        if (imem_ack_i) begin
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (instr_ready_i) begin
          w_accept    = 1'b1;
          w_state_nxt = S_REQ;
`ifdef MISALIGN_CHK_EN
          if (w_misalign) begin
            w_state_nxt = S_FAULT;
          end
`endif
        end
      end
`ifdef MISALIGN_CHK_EN
      S_FAULT: w_state_nxt = S_FAULT;
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register; outputs are registered from the next state.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_instr <= NOP;
      r_req   <= 1'b0;
      r_valid <= 1'b0;
`ifdef MISALIGN_CHK_EN
      r_fault <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_req   <= (w_state_nxt == S_REQ);
      r_valid <= (w_state_nxt == S_HOLD);
`ifdef MISALIGN_CHK_EN
      r_fault <= (w_state_nxt == S_FAULT);
`endif
      if ((r_state == S_REQ) && imem_ack_i) begin
        r_instr <= imem_rdata_i;
      end
      if (w_accept) begin
        r_pc <= w_pc_load;
      end
    end
  end

  assign imem_req_o    = r_req;
  assign imem_addr_o   = r_pc;
  assign pc_o          = r_pc;
  assign instr_o       = r_instr;
  assign instr_valid_o = r_valid;
`ifdef MISALIGN_CHK_EN
  assign fault_o       = r_fault;
`else
  assign fault_o       = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus randomized fetches
// checked against a transaction-level PC/instruction model.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic        branch_i = 1'b0;
  logic        zero_i = 1'b0;
  logic        jal_i = 1'b0;
  logic        jalr_i = 1'b0;
  logic [31:0] imm_i = '0;
  logic [31:0] rs1_data_i = '0;
  logic        fault_o;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_pc;
  bit          faulted;

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(RESET_PC)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
    .instr_o(instr_o), .pc_o(pc_o), .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i),
    .branch_i(branch_i), .zero_i(zero_i), .jal_i(jal_i), .jalr_i(jalr_i),
    .imm_i(imm_i), .rs1_data_i(rs1_data_i), .fault_o(fault_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0BAD_F00D;
  endfunction

  // Architectural next PC: jalr > jal > taken branch > sequential.
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic br, z, jal, jalr,
                                           input logic [31:0] imm, rs1);
    if (jalr)          return (rs1 + imm) & 32'hFFFF_FFFE;
    else if (jal)      return pc + imm;
    else if (br && z)  return pc + imm;
    else               return pc + 32'd4;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic scramble_ctrl();
    branch_i   = 1'($urandom_range(0, 1));
    zero_i     = 1'($urandom_range(0, 1));
    jal_i      = 1'($urandom_range(0, 1));
    jalr_i     = 1'($urandom_range(0, 1));
    imm_i      = $urandom;
    rs1_data_i = $urandom;
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    imem_ack_i = 1'b0;
    instr_ready_i = 1'b0;
    step();
    step();
    check("rst_req", 32'(imem_req_o), 32'd0);
    check("rst_valid", 32'(instr_valid_o), 32'd0);
    check("rst_addr", imem_addr_o, RESET_PC);
    check("rst_pc", pc_o, RESET_PC);
    check("rst_instr", instr_o, NOP);
    check("rst_fault", 32'(fault_o), 32'd0);
    rst_i = 1'b1;
    step();
    m_pc = RESET_PC;
  endtask

  // One full fetch/accept transaction, entered and left in the request state.
  task automatic fetch_one(input int waits, input int hold, input logic br, z, jal, jalr,
                           input logic [31:0] imm, rs1, output bit flt);
    logic [31:0] t;
    flt = 1'b0;
    check("req_on", 32'(imem_req_o), 32'd1);
    check("req_addr", imem_addr_o, m_pc);
    check("req_valid_off", 32'(instr_valid_o), 32'd0);
    for (int w = 0; w < waits; w++) begin
      imem_ack_i = 1'b0;
      scramble_ctrl();
      instr_ready_i = 1'($urandom_range(0, 1));
      step();
      check("wait_req", 32'(imem_req_o), 32'd1);
      check("wait_addr", imem_addr_o, m_pc);
      check("wait_valid", 32'(instr_valid_o), 32'd0);
    end
    imem_ack_i = 1'b1;
    imem_rdata_i = mem_word(m_pc);
    instr_ready_i = 1'b0;
    step();
    imem_ack_i = 1'b0;
    imem_rdata_i = $urandom;
    check("hold_valid", 32'(instr_valid_o), 32'd1);
    check("hold_pc", pc_o, m_pc);
    check("hold_instr", instr_o, mem_word(m_pc));
    check("hold_req", 32'(imem_req_o), 32'd0);
    for (int h = 0; h < hold; h++) begin
      instr_ready_i = 1'b0;
      scramble_ctrl();
      imem_ack_i = 1'($urandom_range(0, 1));
      step();
      imem_ack_i = 1'b0;
      check("stall_valid", 32'(instr_valid_o), 32'd1);
      check("stall_instr", instr_o, mem_word(m_pc));
      check("stall_pc", pc_o, m_pc);
      check("stall_req", 32'(imem_req_o), 32'd0);
    end
    instr_ready_i = 1'b1;
    branch_i = br; zero_i = z; jal_i = jal; jalr_i = jalr; imm_i = imm; rs1_data_i = rs1;
    step();
    instr_ready_i = 1'b0;
    scramble_ctrl();
    t = ref_next(m_pc, br, z, jal, jalr, imm, rs1);
`ifdef MISALIGN_CHK_EN
    if (t[1:0] != 2'b00) begin
      m_pc = t;
      flt = 1'b1;
      for (int k = 0; k < 3; k++) begin
        check("fault_flag", 32'(fault_o), 32'd1);
        check("fault_req", 32'(imem_req_o), 32'd0);
        check("fault_valid", 32'(instr_valid_o), 32'd0);
        check("fault_pc", pc_o, m_pc);
        step();
      end
      return;
    end
`endif
    m_pc = t & 32'hFFFF_FFFC;
    check("acc_valid_drop", 32'(instr_valid_o), 32'd0);
    check("acc_req", 32'(imem_req_o), 32'd1);
    check("acc_addr", imem_addr_o, m_pc);
    check("acc_fault", 32'(fault_o), 32'd0);
  endtask

  initial begin
    do_reset();

    // Sequential fetch with zero wait, a 3-cycle wait, and a 5-cycle decode stall.
    fetch_one(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, faulted);
    check("seq_addr_4", imem_addr_o, 32'h4);
    fetch_one(3, 0, 0, 0, 0, 0, 32'h0, 32'h0, faulted);
    check("seq_addr_8", imem_addr_o, 32'h8);
    fetch_one(0, 5, 0, 0, 0, 0, 32'h0, 32'h0, faulted);
    check("seq_addr_c", imem_addr_o, 32'hC);
    fetch_one(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, faulted);
    check("seq_addr_10", imem_addr_o, 32'h10);

    fetch_one(0, 0, 1, 1, 0, 0, 32'hFFFF_FFF8, 32'h0, faulted);
    check("beq_taken", imem_addr_o, 32'h8);
    fetch_one(0, 0, 0, 0, 0, 1, 32'h0, 32'h10, faulted);
    fetch_one(0, 0, 1, 0, 0, 0, 32'hFFFF_FFF8, 32'h0, faulted);
    check("beq_not_taken", imem_addr_o, 32'h14);
    fetch_one(1, 0, 0, 0, 0, 1, 32'h0, 32'h10, faulted);
    fetch_one(0, 0, 0, 0, 1, 0, 32'h100, 32'h0, faulted);
    check("jal_target", imem_addr_o, 32'h110);
    fetch_one(0, 1, 0, 0, 1, 1, 32'h4, 32'h201, faulted);
    check("jalr_prio", imem_addr_o, 32'h204);

    // PC wraps through the top of the address space.
    fetch_one(0, 0, 0, 0, 0, 1, 32'h0, 32'hFFFF_FFFC, faulted);
    fetch_one(2, 0, 0, 0, 0, 0, 32'h0, 32'h0, faulted);
    check("wrap_zero", imem_addr_o, 32'h0);

    // Reset mid-request; an ack in IDLE must not load the instruction.
    imem_ack_i = 1'b0;
    step();
    check("mid_req", 32'(imem_req_o), 32'd1);
    rst_i = 1'b0;
    imem_ack_i = 1'b1;
    imem_rdata_i = 32'hDEAD_BEEF;
    step();
    check("midrst_req", 32'(imem_req_o), 32'd0);
    check("midrst_instr", instr_o, NOP);
    check("midrst_addr", imem_addr_o, RESET_PC);
    rst_i = 1'b1;
    step();
    imem_ack_i = 1'b0;
    check("idle_ack_ignored", instr_o, NOP);
    check("idle_ack_valid", 32'(instr_valid_o), 32'd0);
    m_pc = RESET_PC;
    fetch_one(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, faulted);

    // Target with bit 1 set: trapped with the check, rounded down without it.
    fetch_one(0, 0, 0, 0, 0, 1, 32'h0, 32'h206, faulted);
`ifdef MISALIGN_CHK_EN
    check("misalign_trap", 32'(faulted), 32'd1);
    do_reset();
`else
    check("misalign_masked", imem_addr_o, 32'h204);
`endif

    for (int n = 0; n < 80; n++) begin
      logic [31:0] imm;
      imm = ($urandom_range(0, 3) == 0) ? $urandom : (32'($urandom_range(0, 1023)) - 32'd512);
      fetch_one(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                imm, $urandom, faulted);
      if (faulted) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
